fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl_if.sv | 19 +
 rtl/fifo_rd_ctrl.sv | 58 +++++
 tb/tb_fifo_rd_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// fifo_rd_ctrl_if: read-side FIFO bundle (request, write pointer in, flags/pointer/address out).
interface fifo_rd_ctrl_if #(parameter int ADDR_WIDTH = 3);
  logic                  RD_inc;
  logic [ADDR_WIDTH:0]   WR_PTR_g;
  logic                  RD_empty;
  logic                  RD_almost_empty;
  logic [ADDR_WIDTH:0]   RD_level;
  logic                  RD_underflow;
  logic [ADDR_WIDTH:0]   RD_PTR_g;
  logic [ADDR_WIDTH-1:0] RD_addr;
  modport master (
    output RD_inc, WR_PTR_g,
    input  RD_empty, RD_almost_empty, RD_level, RD_underflow, RD_PTR_g, RD_addr
  );
  modport slave (
    input  RD_inc, WR_PTR_g,
    output RD_empty, RD_almost_empty, RD_level, RD_underflow, RD_PTR_g, RD_addr
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: async-FIFO read-side pointer, write-pointer synchroniser and registered flags.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter int AE_THRESH   = 1
) (
  input logic RD_CLK,
  input logic RD_RST,
  fifo_rd_ctrl_if.slave rd
);
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] AE  = (AW+1)'(AE_THRESH);
  function automatic logic [AW:0] gray(input logic [AW:0] b);
    return (b >> 1) ^ b;
  endfunction
  logic [SYNC_STAGES-1:0][AW:0] sync_q, sync_d;
  logic [AW:0] rd_bin_q, rd_bin_d, ptr_g_q, ptr_g_d, level_q, level_d, wq, wq_bin;
  logic empty_q, empty_d, ae_q, ae_d, uf_q, uf_d;
  // Flags are computed from the post-read pointer so an accepted read shows up at its own edge.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], rd.WR_PTR_g};
    wq       = sync_q[SYNC_STAGES-1];
    wq_bin   = '0;
    for (int i = 0; i <= AW; i++) wq_bin[i] = ^(wq >> i);
    rd_bin_d = (rd.RD_inc && !empty_q) ? rd_bin_q + ONE : rd_bin_q;
    ptr_g_d  = gray(rd_bin_d);
    level_d  = wq_bin - rd_bin_d;
    empty_d  = ptr_g_d == wq;
    ae_d     = level_d <= AE;
    uf_d     = rd.RD_inc && empty_q;
  end
  always_ff @(posedge RD_CLK or posedge RD_RST) begin
    if (RD_RST) begin
      sync_q   <= '0;
      rd_bin_q <= '0;
      ptr_g_q  <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      ae_q     <= 1'b1;
      uf_q     <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      rd_bin_q <= rd_bin_d;
      ptr_g_q  <= ptr_g_d;
      level_q  <= level_d;
      empty_q  <= empty_d;
      ae_q     <= ae_d;
      uf_q     <= uf_d;
    end
  end
  assign rd.RD_addr         = rd_bin_q[AW-1:0];
  assign rd.RD_PTR_g        = ptr_g_q;
  assign rd.RD_level        = level_q;
  assign rd.RD_empty        = empty_q;
  assign rd.RD_almost_empty = ae_q;
  assign rd.RD_underflow    = uf_q;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed bench with a binary-count reference model feeding a scoreboard queue.
module tb_fifo_rd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  fifo_rd_ctrl_if #(.ADDR_WIDTH(3)) bus ();
  fifo_rd_ctrl #(.ADDR_WIDTH(3), .SYNC_STAGES(2), .AE_THRESH(1)) dut (
    .RD_CLK(clk),
    .RD_RST(rst),
    .rd(bus.slave)
  );
  typedef struct {
    logic [3:0] level;
    logic       empty;
    logic       ae;
    logic       uf;
    logic [2:0] addr;
    logic [3:0] ptrg;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int m_rd, m_w1, m_w2;
  logic m_empty;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [3:0] g4(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction
  task automatic model_reset();
    m_rd = 0;
    m_w1 = 0;
    m_w2 = 0;
    m_empty = 1'b1;
    sb.delete();
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_level"}, 32'(bus.RD_level), 32'd0);
    chk({tag, "_empty"}, 32'(bus.RD_empty), 32'd1);
    chk({tag, "_ae"}, 32'(bus.RD_almost_empty), 32'd1);
    chk({tag, "_uf"}, 32'(bus.RD_underflow), 32'd0);
    chk({tag, "_addr"}, 32'(bus.RD_addr), 32'd0);
    chk({tag, "_ptrg"}, 32'(bus.RD_PTR_g), 32'd0);
  endtask
  // One clock: drive inputs, advance the model, push its prediction, then pop and compare after the edge.
  task automatic cyc(input string tag, input logic inc, input int wbin);
    exp_t e;
    int lvl;
    bus.RD_inc = inc;
    bus.WR_PTR_g = g4(wbin);
    e.uf = inc && m_empty;
    if (inc && !m_empty) m_rd = (m_rd + 1) & 15;
    lvl = (m_w2 - m_rd) & 15;
    m_w2 = m_w1;
    m_w1 = wbin & 15;
    m_empty = (lvl == 0);
    e.level = lvl[3:0];
    e.empty = m_empty;
    e.ae = (lvl <= 1);
    e.addr = m_rd[2:0];
    e.ptrg = g4(m_rd);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, "_level"}, 32'(bus.RD_level), 32'(e.level));
    chk({tag, "_empty"}, 32'(bus.RD_empty), 32'(e.empty));
    chk({tag, "_ae"}, 32'(bus.RD_almost_empty), 32'(e.ae));
    chk({tag, "_uf"}, 32'(bus.RD_underflow), 32'(e.uf));
    chk({tag, "_addr"}, 32'(bus.RD_addr), 32'(e.addr));
    chk({tag, "_ptrg"}, 32'(bus.RD_PTR_g), 32'(e.ptrg));
  endtask
  // Assert reset between edges, confirm outputs clear before any clock, release just after the next edge.
  task automatic async_rst(input string tag);
    #3 rst = 1'b1;
    #1 rst_chk(tag);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  initial begin
    bus.RD_inc = 1'b0;
    bus.WR_PTR_g = '0;
    model_reset();
    #1 rst = 1'b1;
    bus.RD_inc = 1'b1;
    #1 rst_chk("por");
    repeat (2) @(posedge clk);
    #1 rst_chk("por_held");
    rst = 1'b0;
    cyc("rd_after_rel", 1'b1, 0);
    cyc("idle0", 1'b0, 0);
    repeat (3) cyc("w3_sync", 1'b0, 3);
    chk("w3_level_const", 32'(bus.RD_level), 32'd3);
    chk("w3_empty_const", 32'(bus.RD_empty), 32'd0);
    repeat (3) cyc("rd3", 1'b1, 3);
    chk("rd3_ptrg_const", 32'(bus.RD_PTR_g), 32'b0010);
    chk("rd3_empty_const", 32'(bus.RD_empty), 32'd1);
    cyc("underflow", 1'b1, 3);
    chk("underflow_const", 32'(bus.RD_underflow), 32'd1);
    cyc("uf_clear", 1'b0, 3);
    async_rst("mid_rst");
    repeat (3) cyc("w8_sync", 1'b0, 8);
    chk("w8_level_const", 32'(bus.RD_level), 32'd8);
    repeat (8) cyc("rd8", 1'b1, 8);
    chk("wrap_ptrg_const", 32'(bus.RD_PTR_g), 32'b1100);
    chk("wrap_addr_const", 32'(bus.RD_addr), 32'd0);
    repeat (3) cyc("w15_sync", 1'b0, 15);
    chk("w15_level_const", 32'(bus.RD_level), 32'd7);
    cyc("rd_wchg0", 1'b1, 1);
    cyc("rd_wchg1", 1'b1, 1);
    repeat (2) cyc("wchg_settle", 1'b0, 1);
    repeat (2) cyc("rd_to5", 1'b1, 1);
    chk("lvl5_const", 32'(bus.RD_level), 32'd5);
    async_rst("rst_lvl5");
    repeat (4) cyc("post_rst_idle", 1'b0, 0);
    cyc("post_rst_rd", 1'b1, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
